// File: rtl/mrly_relay_card_ctrl.sv
// Relay card controller: SLU register memory, TPIC relay-chain refresh,
// SPI memory dump to the uC, uC bypass of the TPIC chain and a live LED.
module mrly_relay_card_ctrl #(
  parameter int         WIDTH     = 472,
  parameter logic [7:0] CARD_TYPE = 8'h43,
  parameter int         TPIC_DIV  = 4,
  parameter int         LED_HALF  = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  output logic       live_led,
  input  logic       slu_strobe,
  input  logic       slu_rw_n,
  input  logic [7:0] slu_address,
  inout  wire  [7:0] slu_data_bus,
  output logic       tpic_mosi,
  output logic       tpic_clk,
  output logic       tpic_rck,
  output logic       tpic_en_n,
  input  logic       tpic_miso,
  input  logic       diag_en_n,
  input  logic       diag_rck,
  input  logic       diag_byps,
  input  logic       diag_clk,
  input  logic       diag_mosi,
  input  logic       diag_cs_n,
  output logic       diag_miso
);

  localparam int NBYTES  = WIDTH / 8;
  localparam int RELAY_W = WIDTH - 40;
  localparam int CNT_W   = $clog2(RELAY_W);
  localparam int DIV_W   = (TPIC_DIV > 1) ? $clog2(TPIC_DIV) : 1;
  localparam int LED_W   = (LED_HALF > 1) ? $clog2(LED_HALF) : 1;
  localparam logic [0:0] ST_SHIFT = 1'b0;
  localparam logic [0:0] ST_LATCH = 1'b1;

  logic [WIDTH-1:8]   regs_q;
  logic [WIDTH-1:0]   mem_s;
  logic [RELAY_W-1:0] relay_s;
  logic [1:0]         strb_sync_q;
  logic               strb_prev_q;
  logic               slu_wr_s;
  logic [7:0]         rd_data_d, rd_data_q;
  logic [1:0]         cs_sync_q, dclk_sync_q;
  logic               cs_prev_q, dclk_prev_q;
  logic               spi_active_q;
  logic [WIDTH-1:0]   spi_sr_q;
  logic               spi_miso_s;
  logic [DIV_W-1:0]   div_cnt_q;
  logic               tick_s;
  logic [LED_W-1:0]   led_cnt_q;
  logic               led_q;
  logic [0:0]         state_d, state_q;
  logic [CNT_W-1:0]   bit_cnt_d, bit_cnt_q;
  logic               phase_d, phase_q;
  logic [RELAY_W-1:0] snap_d, snap_q;
  logic               mosi_d, mosi_q, sck_d, sck_q, rck_d, rck_q, en_n_d, en_n_q;

  assign mem_s    = {regs_q, CARD_TYPE};
  assign relay_s  = mem_s[WIDTH-1:40];
  assign slu_wr_s = strb_sync_q[1] & ~strb_prev_q & ~slu_rw_n;
  assign slu_data_bus = (slu_rw_n && !reset) ? rd_data_q : 8'hzz;

  // Strobe synchronizer; the write lands on the third clk after the strobe rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      strb_sync_q <= 2'b00;
      strb_prev_q <= 1'b0;
    end else begin
      strb_sync_q <= {strb_sync_q[0], slu_strobe};
      strb_prev_q <= strb_sync_q[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= {(WIDTH-8){1'b0}};
    end else begin
      for (int i = 1; i < NBYTES; i++) begin
        if (slu_wr_s && (slu_address == i[7:0])) begin
          regs_q[i*8 +: 8] <= slu_data_bus;
        end
      end
    end
  end

  // Out-of-range addresses match no byte and read back as zero.
  always_comb begin
    rd_data_d = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      rd_data_d = rd_data_d | ({8{slu_address == i[7:0]}} & mem_s[i*8 +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  // SPI dump slave: zeros shift in behind the image, so the tail reads 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync_q    <= 2'b11;
      cs_prev_q    <= 1'b1;
      dclk_sync_q  <= 2'b00;
      dclk_prev_q  <= 1'b0;
      spi_active_q <= 1'b0;
      spi_sr_q     <= {WIDTH{1'b0}};
    end else begin
      cs_sync_q   <= {cs_sync_q[0], diag_cs_n};
      cs_prev_q   <= cs_sync_q[1];
      dclk_sync_q <= {dclk_sync_q[0], diag_clk};
      dclk_prev_q <= dclk_sync_q[1];
      if (cs_sync_q[1]) begin
        spi_active_q <= 1'b0;
        spi_sr_q     <= {WIDTH{1'b0}};
      end else if (cs_prev_q) begin
        spi_active_q <= 1'b1;
        spi_sr_q     <= mem_s;
      end else if (spi_active_q && !dclk_sync_q[1] && dclk_prev_q) begin
        spi_sr_q <= {spi_sr_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign spi_miso_s = spi_active_q & spi_sr_q[WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= {DIV_W{1'b0}};
      led_cnt_q <= {LED_W{1'b0}};
      led_q     <= 1'b0;
    end else begin
      div_cnt_q <= tick_s ? {DIV_W{1'b0}} : div_cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
      if (led_cnt_q == LED_W'(LED_HALF - 1)) begin
        led_cnt_q <= {LED_W{1'b0}};
        led_q     <= ~led_q;
      end else begin
        led_cnt_q <= led_cnt_q + {{(LED_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign tick_s   = (div_cnt_q == DIV_W'(TPIC_DIV - 1));
  assign live_led = led_q;

  // Refresh engine: two ticks per bit (data with SCK low, then SCK high), then a two-tick latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    snap_d    = snap_q;
    mosi_d    = mosi_q;
    sck_d     = sck_q;
    rck_d     = rck_q;
    en_n_d    = en_n_q;
    if (tick_s) begin
      case (state_q)
        ST_SHIFT: begin
          rck_d = 1'b0;
          if (!phase_q) begin
            sck_d   = 1'b0;
            phase_d = 1'b1;
            en_n_d  = en_n_q & ~rck_q;
            if (bit_cnt_q == {CNT_W{1'b0}}) begin
              mosi_d = relay_s[RELAY_W-1];
              snap_d = {relay_s[RELAY_W-2:0], 1'b0};
            end else begin
              mosi_d = snap_q[RELAY_W-1];
              snap_d = {snap_q[RELAY_W-2:0], 1'b0};
            end
          end else begin
            sck_d   = 1'b1;
            phase_d = 1'b0;
            if (bit_cnt_q == CNT_W'(RELAY_W - 1)) begin
              state_d   = ST_LATCH;
              bit_cnt_d = {CNT_W{1'b0}};
            end else begin
              bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_LATCH: begin
          sck_d   = 1'b0;
          rck_d   = 1'b1;
          phase_d = ~phase_q;
          state_d = phase_q ? ST_SHIFT : ST_LATCH;
        end
        default: begin
          state_d = ST_SHIFT;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_SHIFT;
      bit_cnt_q <= {CNT_W{1'b0}};
      phase_q   <= 1'b0;
      snap_q    <= {RELAY_W{1'b0}};
      mosi_q    <= 1'b0;
      sck_q     <= 1'b0;
      rck_q     <= 1'b0;
      en_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      snap_q    <= snap_d;
      mosi_q    <= mosi_d;
      sck_q     <= sck_d;
      rck_q     <= rck_d;
      en_n_q    <= en_n_d;
    end
  end

  assign tpic_mosi = diag_byps ? diag_mosi : mosi_q;
  assign tpic_clk  = diag_byps ? diag_clk  : sck_q;
  assign tpic_rck  = diag_byps ? diag_rck  : rck_q;
  assign tpic_en_n = diag_byps ? diag_en_n : en_n_q;
  assign diag_miso = diag_byps ? tpic_miso : spi_miso_s;

endmodule

// File: tb/tb_mrly_relay_card_ctrl.sv
// Self-checking bench for mrly_relay_card_ctrl: reference memory model plus
// expectation queues filled as stimulus is driven.
module tb_mrly_relay_card_ctrl;
  localparam int WIDTH    = 472;
  localparam int NB       = WIDTH / 8;
  localparam int RELAY_W  = WIDTH - 40;
  localparam int LED_HALF = 64;

  logic clk = 1'b0;
  logic reset, slu_strobe, slu_rw_n, tpic_miso;
  logic [7:0] slu_address, bus_drv;
  logic bus_en;
  logic diag_en_n, diag_rck, diag_byps, diag_clk, diag_mosi, diag_cs_n;
  logic live_led, tpic_mosi, tpic_clk, tpic_rck, tpic_en_n, diag_miso;
  wire [7:0] slu_data_bus;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] tb_mem;
  logic [7:0] exp_byte_q[$];
  logic       exp_bit_q[$];

  assign slu_data_bus = bus_en ? bus_drv : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (slu_data_bus[g]);
  end

  always #10 clk = ~clk;

  mrly_relay_card_ctrl #(.WIDTH(WIDTH), .CARD_TYPE(8'h43), .TPIC_DIV(4), .LED_HALF(LED_HALF)) dut (
    .clk(clk), .reset(reset), .live_led(live_led),
    .slu_strobe(slu_strobe), .slu_rw_n(slu_rw_n), .slu_address(slu_address), .slu_data_bus(slu_data_bus),
    .tpic_mosi(tpic_mosi), .tpic_clk(tpic_clk), .tpic_rck(tpic_rck), .tpic_en_n(tpic_en_n), .tpic_miso(tpic_miso),
    .diag_en_n(diag_en_n), .diag_rck(diag_rck), .diag_byps(diag_byps), .diag_clk(diag_clk),
    .diag_mosi(diag_mosi), .diag_cs_n(diag_cs_n), .diag_miso(diag_miso)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    tb_mem = '0;
    tb_mem[7:0] = 8'h43;
  endtask

  task automatic slu_write(input logic [7:0] a, input logic [7:0] d);
    slu_rw_n = 1'b0; slu_address = a; bus_drv = d; bus_en = 1'b1; tick(1);
    slu_strobe = 1'b1; tick(4); slu_strobe = 1'b0; tick(1);
    bus_en = 1'b0; slu_rw_n = 1'b1; tick(1);
    if (a != 8'h00 && int'(a) < NB) tb_mem[int'(a)*8 +: 8] = d;
  endtask

  task automatic slu_read(input logic [7:0] a, output logic [7:0] got);
    slu_rw_n = 1'b1; slu_address = a;
    exp_byte_q.push_back((int'(a) < NB) ? tb_mem[int'(a)*8 +: 8] : 8'h00);
    slu_strobe = 1'b1; tick(4); slu_strobe = 1'b0; tick(1);
    got = slu_data_bus;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(4);
    checks++;
    if (slu_data_bus !== 8'hFF) begin errors++; $display("FAIL reset_bus_z: got %h expected FF (released)", slu_data_bus); end
    reset = 1'b0; tick(1);
    checks++;
    if ({tpic_en_n, tpic_clk, tpic_rck, tpic_mosi, live_led, diag_miso} !== 6'b100000) begin
      errors++; $display("FAIL reset_outputs: got en_n/clk/rck/mosi/led/miso=%b expected 100000",
                         {tpic_en_n, tpic_clk, tpic_rck, tpic_mosi, live_led, diag_miso});
    end
  endtask

  task automatic test_tpic_enable();
    int n = 0;
    while (tpic_rck !== 1'b1 && n < 5000) begin tick(1); n++; end
    checks++;
    if (n >= 5000) begin errors++; $display("FAIL first_latch_timeout: got no rck within %0d clk expected a pulse", n); end
    checks++;
    if (tpic_en_n !== 1'b1) begin errors++; $display("FAIL en_n_before_latch: got %b expected 1", tpic_en_n); end
    n = 0;
    while (tpic_rck === 1'b1 && n < 100) begin tick(1); n++; end
    checks++;
    if (tpic_en_n !== 1'b0) begin errors++; $display("FAIL en_n_after_latch: got %b expected 0", tpic_en_n); end
  endtask

  task automatic test_bypass();
    logic v;
    diag_byps = 1'b1;
    for (int k = 0; k < 2; k++) begin
      v = (k == 0);
      diag_clk = v; diag_rck = v; diag_en_n = v; diag_mosi = v; tpic_miso = v;
      tick(1);
      checks++;
      if ({tpic_mosi, tpic_clk, tpic_rck, tpic_en_n, diag_miso} !== {5{v}}) begin
        errors++; $display("FAIL bypass_%0b: got mosi/clk/rck/en_n/miso=%b expected %b",
                           v, {tpic_mosi, tpic_clk, tpic_rck, tpic_en_n, diag_miso}, {5{v}});
      end
    end
    diag_byps = 1'b0; tick(2);
  endtask

  task automatic test_card_type();
    logic [7:0] got, exp;
    slu_read(8'h00, got); exp = exp_byte_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL card_type: got %h expected %h", got, exp); end
    slu_write(8'h00, 8'h12);
    slu_read(8'h00, got); exp = exp_byte_q.pop_front(); checks++;
    if (got !== exp || got !== 8'h43) begin errors++; $display("FAIL card_type_ro: got %h expected 43", got); end
  endtask

  task automatic test_slu_rw();
    logic [7:0] got, exp;
    logic [7:0] addrs [5] = '{8'h03, 8'h40, 8'h3A, 8'h3B, 8'h01};
    slu_write(8'h03, 8'h55);
    slu_write(8'h3A, 8'h3C);
    slu_write(8'h3B, 8'h77);
    for (int k = 0; k < 5; k++) begin
      slu_read(addrs[k], got); exp = exp_byte_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL slu_read_%h: got %h expected %h", addrs[k], got, exp); end
    end
    slu_rw_n = 1'b0; slu_address = 8'h03; tick(2); checks++;
    if (slu_data_bus !== 8'hFF) begin errors++; $display("FAIL bus_z_on_write: got %h expected FF (released)", slu_data_bus); end
    slu_rw_n = 1'b1; tick(1);
  endtask

  task automatic test_spi_dump(input string nm, input logic [7:0] exp_first);
    logic b, e;
    logic [7:0] first8, last8;
    first8 = 8'h00; last8 = 8'h00;
    diag_cs_n = 1'b0; tick(10);
    for (int i = 0; i < WIDTH + 1; i++) begin
      exp_bit_q.push_back((i < WIDTH) ? tb_mem[WIDTH-1-i] : 1'b0);
      b = diag_miso; diag_clk = 1'b1; tick(5); diag_clk = 1'b0; tick(5);
      e = exp_bit_q.pop_front(); checks++;
      if (b !== e) begin errors++; $display("FAIL %s_bit%0d: got %b expected %b", nm, i, b, e); end
      if (i < 8) first8 = {first8[6:0], b};
      else if (i >= WIDTH - 8 && i < WIDTH) last8 = {last8[6:0], b};
    end
    checks++;
    if (first8 !== exp_first) begin errors++; $display("FAIL %s_first8: got %h expected %h", nm, first8, exp_first); end
    checks++;
    if (last8 !== 8'h43) begin errors++; $display("FAIL %s_last8: got %h expected 43", nm, last8); end
    diag_cs_n = 1'b1; tick(5); checks++;
    if (diag_miso !== 1'b0) begin errors++; $display("FAIL %s_idle_miso: got %b expected 0", nm, diag_miso); end
  endtask

  task automatic test_tpic_refresh();
    int n, rises, ones;
    logic prev_sck, got, e, first;
    slu_write(8'h3A, 8'h80);
    n = 0;
    while (tpic_rck !== 1'b1 && n < 5000) begin tick(1); n++; end
    while (tpic_rck === 1'b1 && n < 5000) begin tick(1); n++; end
    checks++;
    if (n >= 5000) begin errors++; $display("FAIL refresh_sync_timeout: got %0d clk expected a latch", n); end
    for (int k = 0; k < RELAY_W; k++) exp_bit_q.push_back(tb_mem[WIDTH-1-k]);
    rises = 0; ones = 0; first = 1'b0; prev_sck = tpic_clk; n = 0;
    while (tpic_rck !== 1'b1 && n < 5000) begin
      tick(1); n++;
      if (tpic_clk === 1'b1 && prev_sck === 1'b0) begin
        got = tpic_mosi;
        if (rises == 0) first = got;
        if (got === 1'b1) ones++;
        rises++;
        if (exp_bit_q.size() > 0) begin
          e = exp_bit_q.pop_front(); checks++;
          if (got !== e) begin errors++; $display("FAIL tpic_bit%0d: got %b expected %b", rises - 1, got, e); end
        end
      end
      prev_sck = tpic_clk;
    end
    exp_bit_q.delete();
    checks++;
    if (rises != RELAY_W) begin errors++; $display("FAIL tpic_rises: got %0d expected %0d", rises, RELAY_W); end
    checks++;
    if (first !== 1'b1 || ones != 1) begin errors++; $display("FAIL tpic_pattern: got first=%b ones=%0d expected first=1 ones=1", first, ones); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got, exp;
    logic [7:0] addrs [3] = '{8'h03, 8'h00, 8'h3A};
    diag_cs_n = 1'b0; tick(10);
    for (int k = 0; k < 3; k++) begin diag_clk = 1'b1; tick(5); diag_clk = 1'b0; tick(5); end
    slu_rw_n = 1'b1; slu_address = 8'h03;
    reset = 1'b1; tick(3);
    checks++;
    if (slu_data_bus !== 8'hFF) begin errors++; $display("FAIL mid_reset_bus_z: got %h expected FF (released)", slu_data_bus); end
    checks++;
    if ({tpic_en_n, tpic_clk, tpic_rck, live_led} !== 4'b1000) begin
      errors++; $display("FAIL mid_reset_outputs: got en_n/clk/rck/led=%b expected 1000", {tpic_en_n, tpic_clk, tpic_rck, live_led});
    end
    reset = 1'b0; model_clear();
    diag_cs_n = 1'b1; tick(5); checks++;
    if (diag_miso !== 1'b0) begin errors++; $display("FAIL mid_reset_miso: got %b expected 0", diag_miso); end
    for (int k = 0; k < 3; k++) begin
      slu_read(addrs[k], got); exp = exp_byte_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL mid_reset_read_%h: got %h expected %h", addrs[k], got, exp); end
    end
  endtask

  task automatic test_led();
    logic v;
    int n = 0;
    v = live_led;
    while (live_led === v && n < 4 * LED_HALF) begin tick(1); n++; end
    v = live_led; n = 0;
    while (live_led === v && n < 4 * LED_HALF) begin tick(1); n++; end
    checks++;
    if (n != LED_HALF) begin errors++; $display("FAIL led_half_period: got %0d clk expected %0d", n, LED_HALF); end
  endtask

  initial begin
    reset = 1'b1; slu_strobe = 1'b0; slu_rw_n = 1'b1; slu_address = 8'h00;
    bus_drv = 8'h00; bus_en = 1'b0; tpic_miso = 1'b0;
    diag_en_n = 1'b0; diag_rck = 1'b0; diag_byps = 1'b0; diag_clk = 1'b0; diag_mosi = 1'b0; diag_cs_n = 1'b1;
    model_clear();
    test_reset();
    test_tpic_enable();
    test_bypass();
    test_card_type();
    test_slu_rw();
    test_spi_dump("spi_dump1", 8'h3C);
    slu_write(8'h3A, 8'hA5);
    test_spi_dump("spi_dump2", 8'hA5);
    test_tpic_refresh();
    test_reset_mid();
    test_led();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mrly_relay_card_ctrl.md
Name: mrly_relay_card_ctrl

Overview:
- Top-level controller of a relay card.
- Holds a WIDTH-bit byte-addressed register memory that the SLU writes and reads over an 8-bit parallel strobe bus.
- Continuously refreshes the TPIC relay-driver shift-register chain from the memory, and lets a uC dump the whole memory over an SPI slave port.
- A bypass input hands the TPIC chain directly to the uC SPI lines; a live LED blinks.

Parameters:
- WIDTH, 472: memory width in bits (59 bytes); multiple of 8.
- CARD_TYPE, 8'h43: read-only value of byte 0.
- TPIC_DIV, 4: clk divisor for the TPIC tick (50 MHz -> 12.5 MHz).
- LED_HALF, 25000000: clk cycles per LED toggle.

Ports:
- clk in 1: 50 MHz system clock; the only clock.
- reset in 1: synchronous, active-high.
- live_led out 1: blink output.
- slu_strobe in 1: SLU access strobe, asynchronous.
- slu_rw_n in 1: 1 = card drives bus (read); 0 = card samples bus (write).
- slu_address in 8: byte address.
- slu_data_bus inout 8: tri-state data bus.
- tpic_mosi, tpic_clk, tpic_rck, tpic_en_n out 1 each: TPIC chain SI, SCK, RCK and active-low G.
- tpic_miso in 1: TPIC chain SO.
- diag_en_n, diag_rck, diag_byps, diag_clk, diag_mosi, diag_cs_n in 1 each: uC lines.
- diag_miso out 1: uC MISO.

Behaviour:
- Memory layout: byte n = mem[8n+7:8n].
  - Byte 0 is hard-wired to CARD_TYPE.
  - Bytes 1..WIDTH/8-1 are registers, cleared to 0 on reset.
  - Relay image = mem[WIDTH-1:40] (bytes 5..58, 432 bits).
- Bypass, combinational:
  - diag_byps=1: tpic_mosi=diag_mosi, tpic_clk=diag_clk, tpic_rck=diag_rck, tpic_en_n=diag_en_n, diag_miso=tpic_miso.
  - diag_byps=0: TPIC outputs come from the refresh engine; diag_miso comes from the SPI slave.
- SLU interface:
  - slu_strobe passes through a 2-FF synchronizer; rising edge is detected in the clk domain.
  - Write: on a detected rise with slu_rw_n=0, byte[slu_address] <= slu_data_bus. This happens 3 clk after the strobe rises.
  - Writes to address 0 or to addresses >= WIDTH/8 are ignored.
  - Strobe must stay high >= 3 clk, and address/data must be stable across that window.
  - Read: while slu_rw_n=1 and reset=0, drive slu_data_bus with a registered copy of byte[slu_address], refreshed every clk. Out-of-range addresses return 8'h00.
  - Otherwise slu_data_bus is high-Z. During reset the bus is high-Z.
- SPI slave (memory dump, mode 0, diag_mosi ignored):
  - diag_clk and diag_cs_n are synchronized with 2 FFs; diag_clk must stay <= clk/8.
  - On a detected cs_n fall, load the shift register with mem and present mem[WIDTH-1] on diag_miso.
  - Each detected diag_clk falling edge shifts out the next lower bit.
  - Stream order: mem[WIDTH-1] down to mem[0], i.e. byte 58 first, each byte MSB first; CARD_TYPE is the last 8 bits.
  - After WIDTH bits, output 0.
  - cs_n high: diag_miso=0 and the shifter is idle.
  - A cs_n rise mid-frame aborts the frame; the next fall restarts from mem[WIDTH-1].
- Divider: clk-enable pulse of 1 clk every TPIC_DIV clk (a 12.5 MHz tick).
- TPIC refresh engine, tick-driven, endless loop:
  - SHIFT: 432 bits, mem[WIDTH-1] first. Each bit lasts 2 ticks; data is set with tpic_clk low, then tpic_clk goes high for the second tick (6.25 MHz SCK).
  - LATCH: tpic_clk=0, tpic_rck=1 for 2 ticks.
  - Then return to SHIFT.
  - A snapshot of the relay image is taken at the start of each SHIFT.
  - tpic_en_n=1 from reset until the first LATCH completes, then 0.
- Reset values: tpic_clk/rck/mosi=0, tpic_en_n=1, state=SHIFT bit 0, live_led=0, counters=0.
- live_led toggles every LED_HALF clk.

Test Plan:
- Bypass: diag_byps=1; drive diag_clk/rck/en_n/mosi and tpic_miso to 1, then to 0 -> each TPIC output equals its diag input and diag_miso equals tpic_miso at both values.
- Card type: after reset, rw_n=1, address 0x00, strobe pulse of 4 clk -> slu_data_bus=0x43. Then write 0x12 to address 0 -> still reads 0x43.
- SLU write/read: write 0x55 to address 0x03, read back address 0x03 -> 0x55. Address 0x40 reads 0x00. With rw_n=0 the bus is high-Z.
- SPI dump: diag_cs_n low, 472 diag_clk cycles at clk/10, sample on rising edge -> last 8 bits are 0x43 MSB first. After writing 0xA5 to byte 58, the first 8 bits are 0xA5.
- TPIC refresh: write 0x80 to byte 58 -> first tpic_mosi bit is 1 and the rest are 0; 432 tpic_clk rises precede each tpic_rck pulse; tpic_en_n goes 0 after the first latch.
- Reset mid-SPI/mid-shift: assert reset -> registers 0 (byte 0 still 0x43), tpic_en_n=1, live_led=0.
